// File: rtl/imm_gen_pipe.sv
// Registered RV immediate decoder with a 2-entry (main + skid) output buffer.
// Decodes the full 7-bit opcode, sign-extends to XLEN and carries a sideband tag.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);

    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;
    localparam logic [2:0] FMT_Z    = 3'd6;

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [2:0]       fmt;
        logic             illegal;
        logic [TAG_W-1:0] tag;
    } beat_t;

    beat_t       dec;
    logic [31:0] imm32;

    beat_t main_q, main_d;
    beat_t skid_q, skid_d;
    logic  main_valid_q, main_valid_d;
    logic  skid_valid_q, skid_valid_d;
    logic  accept;
    logic  out_fire;

    // Every listed opcode ends in 2'b11, so compressed words fall into default.
    always_comb begin
        imm32       = '0;
        dec.fmt     = FMT_NONE;
        dec.illegal = 1'b0;
        dec.tag     = in_tag;
        case (in_inst[6:0])
            7'b0000011, 7'b0010011, 7'b1100111: begin
                dec.fmt = FMT_I;
                imm32   = {{20{in_inst[31]}}, in_inst[31:20]};
            end
            7'b0100011: begin
                dec.fmt = FMT_S;
                imm32   = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
            end
            7'b1100011: begin
                dec.fmt = FMT_B;
                imm32   = {{20{in_inst[31]}}, in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                dec.fmt = FMT_U;
                imm32   = {in_inst[31:12], 12'b0};
            end
            7'b1101111: begin
                dec.fmt = FMT_J;
                imm32   = {{12{in_inst[31]}}, in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
            end
            7'b1110011: begin
                if (in_inst[14]) begin
                    dec.fmt = FMT_Z;
                    imm32   = {27'b0, in_inst[19:15]};
                end else begin
                    dec.fmt = FMT_I;
                    imm32   = {{20{in_inst[31]}}, in_inst[31:20]};
                end
            end
            7'b0110011, 7'b0001111: dec.fmt = FMT_NONE;
            7'b0011011: begin
                if (XLEN == 64) begin
                    dec.fmt = FMT_I;
                    imm32   = {{20{in_inst[31]}}, in_inst[31:20]};
                end else begin
                    dec.illegal = 1'b1;
                end
            end
            7'b0111011: dec.illegal = (XLEN != 64);
            default:    dec.illegal = 1'b1;
        endcase
        // imm32 bit 31 is the true sign for every format (0 for Z and NONE).
        dec.imm = XLEN'($signed(imm32));
    end

    assign in_ready = ~skid_valid_q;
    assign accept   = in_valid & ~skid_valid_q & ~flush;
    assign out_fire = main_valid_q & out_ready;

    // A full skid implies a full main, so a skid drain only happens on out_fire.
    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q || out_fire) begin
            if (skid_valid_q) begin
                main_d       = skid_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_d       = dec;
                main_valid_d = 1'b1;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d       = dec;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign out_valid   = main_valid_q;
    assign out_imm     = main_q.imm;
    assign out_fmt     = main_q.fmt;
    assign out_illegal = main_q.illegal;
    assign out_tag     = main_q.tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed-vector bench for imm_gen_pipe: an XLEN=32 instance plus an XLEN=64 instance.
module tb_imm_gen_pipe;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid, in_ready, out_valid, out_ready, out_illegal;
    logic [31:0] in_inst, in_tag, out_imm, out_tag;
    logic [2:0]  out_fmt;

    logic        w_in_valid, w_in_ready, w_out_valid, w_out_illegal;
    logic [31:0] w_in_inst, w_in_tag, w_out_tag;
    logic [63:0] w_out_imm;
    logic [2:0]  w_out_fmt;

    int n_checks = 0;
    int n_pass   = 0;

    imm_gen_pipe #(.XLEN(32), .TAG_W(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
        .out_fmt(out_fmt), .out_illegal(out_illegal), .out_tag(out_tag)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
        .clk(clk), .rst(rst), .flush(1'b0),
        .in_valid(w_in_valid), .in_ready(w_in_ready), .in_inst(w_in_inst), .in_tag(w_in_tag),
        .out_valid(w_out_valid), .out_ready(1'b1), .out_imm(w_out_imm),
        .out_fmt(w_out_fmt), .out_illegal(w_out_illegal), .out_tag(w_out_tag)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
            $display("ok   %-14s got=0x%0h", name, got);
        end else begin
            $display("FAIL %-14s got=0x%0h exp=0x%0h", name, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Present one beat on the 32-bit instance for a single edge, then check the decode.
    task automatic one32(input string name, input logic [31:0] inst, input logic [31:0] imm,
                         input logic [2:0] fmt, input logic ill);
        in_valid = 1'b1; in_inst = inst; in_tag = inst ^ 32'h5A5A_0000;
        tick;
        in_valid = 1'b0;
        check({name, "_v"},   {63'b0, out_valid}, 64'd1);
        check({name, "_imm"}, {32'b0, out_imm}, {32'b0, imm});
        check({name, "_fmt"}, {61'b0, out_fmt}, {61'b0, fmt});
        check({name, "_ill"}, {63'b0, out_illegal}, {63'b0, ill});
        check({name, "_tag"}, {32'b0, out_tag}, {32'b0, inst ^ 32'h5A5A_0000});
    endtask

    task automatic one64(input string name, input logic [31:0] inst, input logic [63:0] imm,
                         input logic [2:0] fmt, input logic ill);
        w_in_valid = 1'b1; w_in_inst = inst; w_in_tag = inst;
        tick;
        w_in_valid = 1'b0;
        check({name, "_v"},   {63'b0, w_out_valid}, 64'd1);
        check({name, "_imm"}, w_out_imm, imm);
        check({name, "_fmt"}, {61'b0, w_out_fmt}, {61'b0, fmt});
        check({name, "_ill"}, {63'b0, w_out_illegal}, {63'b0, ill});
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
        in_valid = 1'b1; in_inst = 32'hFFF0_0093; in_tag = 32'd99;
        w_in_valid = 1'b1; w_in_inst = 32'h8000_0037; w_in_tag = 32'd98;
        tick; tick;
        check("rst_out_valid", {63'b0, out_valid}, 64'd0);
        check("rst_in_ready",  {63'b0, in_ready}, 64'd1);
        check("rst_imm",       {32'b0, out_imm}, 64'd0);
        check("rst_fmt",       {61'b0, out_fmt}, 64'd0);
        check("rst_ill",       {63'b0, out_illegal}, 64'd0);
        check("rst_tag",       {32'b0, out_tag}, 64'd0);
        check("rst64_valid",   {63'b0, w_out_valid}, 64'd0);
        rst = 1'b0; in_valid = 1'b0; w_in_valid = 1'b0;
        tick;
        check("rst_no_accept", {63'b0, out_valid}, 64'd0);

        // addi x1,x0,-1
        in_valid = 1'b1; in_inst = 32'hFFF0_0093; in_tag = 32'hAA;
        tick;
        in_valid = 1'b0;
        check("addi_v",   {63'b0, out_valid}, 64'd1);
        check("addi_imm", {32'b0, out_imm}, 64'hFFFF_FFFF);
        check("addi_fmt", {61'b0, out_fmt}, 64'd1);
        check("addi_ill", {63'b0, out_illegal}, 64'd0);
        check("addi_tag", {32'b0, out_tag}, 64'hAA);
        tick;
        check("addi_drain", {63'b0, out_valid}, 64'd0);

        // back-to-back stream: sw, jal, beq
        in_valid = 1'b1; in_inst = 32'hFE11_2E23; in_tag = 32'd1;
        tick;
        check("sw_imm", {32'b0, out_imm}, 64'hFFFF_FFFC);
        check("sw_fmt", {61'b0, out_fmt}, 64'd2);
        in_inst = 32'hFF9F_F06F; in_tag = 32'd2;
        tick;
        check("jal_imm", {32'b0, out_imm}, 64'hFFFF_FFF8);
        check("jal_fmt", {61'b0, out_fmt}, 64'd5);
        in_inst = 32'h0000_0863; in_tag = 32'd3;
        tick;
        in_valid = 1'b0;
        check("beq_imm", {32'b0, out_imm}, 64'h10);
        check("beq_fmt", {61'b0, out_fmt}, 64'd3);
        check("beq_tag", {32'b0, out_tag}, 64'd3);
        tick;

        // stall: lui with tags 1,2,3 while out_ready=0 for three edges
        out_ready = 1'b0;
        in_valid = 1'b1; in_inst = 32'h1234_50B7; in_tag = 32'd1;
        tick;
        check("stall1_tag", {32'b0, out_tag}, 64'd1);
        check("stall1_rdy", {63'b0, in_ready}, 64'd1);
        in_tag = 32'd2;
        tick;
        check("stall2_tag", {32'b0, out_tag}, 64'd1);
        check("stall2_rdy", {63'b0, in_ready}, 64'd0);
        in_tag = 32'd3;
        tick;
        check("stall3_tag", {32'b0, out_tag}, 64'd1);
        check("stall3_imm", {32'b0, out_imm}, 64'h1234_5000);
        check("stall3_rdy", {63'b0, in_ready}, 64'd0);
        out_ready = 1'b1;
        tick;
        check("rel1_tag", {32'b0, out_tag}, 64'd2);
        check("rel1_imm", {32'b0, out_imm}, 64'h1234_5000);
        check("rel1_rdy", {63'b0, in_ready}, 64'd1);
        tick;
        in_valid = 1'b0;
        check("rel2_tag", {32'b0, out_tag}, 64'd3);
        check("rel2_v",   {63'b0, out_valid}, 64'd1);
        tick;
        check("rel3_v", {63'b0, out_valid}, 64'd0);

        // flush with both entries full and a beat presented
        out_ready = 1'b0;
        in_valid = 1'b1; in_inst = 32'h1234_50B7; in_tag = 32'h11;
        tick;
        in_tag = 32'h12;
        tick;
        check("fl_full_rdy", {63'b0, in_ready}, 64'd0);
        in_tag = 32'h13; flush = 1'b1;
        tick;
        flush = 1'b0; in_valid = 1'b0;
        check("fl_v",   {63'b0, out_valid}, 64'd0);
        check("fl_rdy", {63'b0, in_ready}, 64'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            check("fl_gone", {63'b0, out_valid}, 64'd0);
        end
        // flush into an empty buffer also blocks the presented beat
        in_valid = 1'b1; in_tag = 32'h14; flush = 1'b1;
        tick;
        flush = 1'b0; in_valid = 1'b0;
        check("fl_noacc", {63'b0, out_valid}, 64'd0);

        // illegal words, CSR zimm, RV64-only opcodes on the 32-bit instance
        one32("zero",   32'h0000_0000, 32'h0, 3'd0, 1'b1);
        one32("op7f",   32'h0000_007F, 32'h0, 3'd0, 1'b1);
        one32("csrrwi", 32'h340F_D073, 32'h1F, 3'd6, 1'b0);
        one32("addiw32", 32'hFFF0_809B, 32'h0, 3'd0, 1'b1);
        one32("op32_32", 32'h0000_003B, 32'h0, 3'd0, 1'b1);
        one32("add",    32'h0020_80B3, 32'h0, 3'd0, 1'b0);

        // XLEN=64 instance
        one64("lui64",   32'h8000_0037, 64'hFFFF_FFFF_8000_0000, 3'd4, 1'b0);
        one64("addiw64", 32'hFFF0_809B, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b0);
        one64("op32_64", 32'h0000_003B, 64'h0, 3'd0, 1'b0);
        tick;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
